// File: rtl/bw_store_fwd_queue_if.sv
// Request record type plus the bundled port interface of bw_store_fwd_queue.
// The master side is the address-generation/cache-port driver, the slave side is the queue.
package bw_sq_pkg;

    typedef enum logic [2:0] {
        MR_NOP,
        MR_LOAD,
        MR_LOADZ,
        MR_STORE
    } mr_func_t;

    typedef enum logic [2:0] {
        SZ_BYT,
        SZ_WYDE,
        SZ_TETRA,
        SZ_PENTA,
        SZ_OCTA,
        SZ_DECI
    } mr_size_t;

    typedef struct packed {
        mr_func_t    func;
        logic [31:0] adr;
        mr_size_t    sz;
        logic [63:0] dat;
        logic [7:0]  tid;
    } MemoryRequest;

    function automatic logic [15:0] sel_of(input mr_size_t sz);
        case (sz)
            SZ_BYT:   return 16'h0001;
            SZ_WYDE:  return 16'h0003;
            SZ_TETRA: return 16'h000F;
            SZ_PENTA: return 16'h001F;
            SZ_OCTA:  return 16'h00FF;
            SZ_DECI:  return 16'h03FF;
            default:  return 16'h00FF;
        endcase
    endfunction

    // Bytes actually carried in the 64-bit data word; deci is clipped to the word.
    function automatic int size_bytes(input mr_size_t sz);
        case (sz)
            SZ_BYT:   return 1;
            SZ_WYDE:  return 2;
            SZ_TETRA: return 4;
            SZ_PENTA: return 5;
            default:  return 8;
        endcase
    endfunction

    function automatic logic [63:0] byte_mask(input MemoryRequest r);
        return 64'(sel_of(r.sz)) << r.adr[3:0];
    endfunction

endpackage

interface bw_store_fwd_queue_if
    import bw_sq_pkg::*;
#(
    parameter int QDEP  = 8,
    parameter int NPORT = 2
) ();

    logic [NPORT-1:0]           wr;
    MemoryRequest               i [NPORT];
    logic [NPORT-1:0]           wr_ack;
    MemoryRequest               ldo [NPORT];
    logic [NPORT-1:0]           found;
    logic [NPORT-1:0]           conflict;
    logic                       rd;
    MemoryRequest               o;
    logic                       valid;
    logic                       empty;
    logic                       full;
    logic [$clog2(QDEP+1)-1:0]  count;

    modport master (
        output wr, i, rd,
        input  wr_ack, ldo, found, conflict, o, valid, empty, full, count
    );

    modport slave (
        input  wr, i, rd,
        output wr_ack, ldo, found, conflict, o, valid, empty, full, count
    );

endinterface

// File: rtl/bw_store_fwd_queue.sv
// Multi-port circular memory request queue with duplicate-tid suppression.
// Store-to-load forwarding and partial-overlap conflict detection exist only when BW_SQ_FWD_EN is defined.
module bw_store_fwd_queue
    import bw_sq_pkg::*;
#(
    parameter int QDEP  = 8,
    parameter int NPORT = 2,
    parameter int AWID  = 32
) (
    input logic                 clk,
    input logic                 rst,
    bw_store_fwd_queue_if.slave bus
);

    localparam int PW = $clog2(QDEP);
    localparam int CW = $clog2(QDEP + 1);

    MemoryRequest      mem [QDEP];
    logic [QDEP-1:0]   vld;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     cnt;
    logic [7:0]        last_tid;
    logic [7:0]        next_last_tid;
    logic [NPORT-1:0]  ack_q;
    logic [NPORT-1:0]  accepted;
    logic [NPORT-1:0]  written;
    logic [NPORT-1:0]  found_c;
    logic [NPORT-1:0]  conflict_c;
    logic [PW-1:0]     wr_idx [NPORT];
    logic [CW-1:0]     n_written;
    MemoryRequest      ldo_c [NPORT];
    logic              pop;

    assign pop          = bus.rd & vld[head];
    assign bus.o        = mem[head];
    assign bus.valid    = vld[head];
    assign bus.empty    = (cnt == '0);
    assign bus.full     = (cnt == CW'(QDEP));
    assign bus.count    = cnt;
    assign bus.wr_ack   = ack_q;
    assign bus.found    = found_c;
    assign bus.conflict = conflict_c;
    assign bus.ldo      = ldo_c;

`ifdef BW_SQ_FWD_EN
    logic [63:0] msk [QDEP];

    // Scanning oldest to youngest lets the last hit stand as the youngest overlapping store.
    always_comb begin : search
        logic [63:0]   lmask;
        logic          hit;
        logic [PW-1:0] idx;
        logic [PW-1:0] hit_idx;
        logic [63:0]   shifted;
        logic [63:0]   res;
        int            nb;
        lmask   = '0;
        hit     = 1'b0;
        idx     = '0;
        hit_idx = '0;
        shifted = '0;
        res     = '0;
        nb      = 1;
        for (int p = 0; p < NPORT; p++) begin
            lmask         = byte_mask(bus.i[p]);
            hit           = 1'b0;
            hit_idx       = '0;
            shifted       = '0;
            res           = '0;
            nb            = size_bytes(bus.i[p].sz);
            found_c[p]    = 1'b0;
            conflict_c[p] = 1'b0;
            ldo_c[p]      = bus.i[p];
            if (bus.i[p].func == MR_LOAD || bus.i[p].func == MR_LOADZ) begin
                for (int k = 0; k < QDEP; k++) begin
                    idx = head + PW'(k);
                    if (vld[idx] && mem[idx].func == MR_STORE &&
                        mem[idx].adr[AWID-1:4] == bus.i[p].adr[AWID-1:4] &&
                        (msk[idx] & lmask) != '0) begin
                        hit     = 1'b1;
                        hit_idx = idx;
                    end
                end
                if (hit) begin
                    if ((lmask & ~msk[hit_idx]) == '0) begin
                        found_c[p] = 1'b1;
                        shifted = mem[hit_idx].dat >>
                                  {bus.i[p].adr[3:0] - mem[hit_idx].adr[3:0], 3'b000};
                        for (int b = 0; b < 8; b++) begin
                            if (b < nb)
                                res[8*b +: 8] = shifted[8*b +: 8];
                            else if (bus.i[p].func == MR_LOAD && shifted[8*nb-1])
                                res[8*b +: 8] = 8'hFF;
                            else
                                res[8*b +: 8] = 8'h00;
                        end
                        ldo_c[p].dat = res;
                    end else begin
                        conflict_c[p] = 1'b1;
                    end
                end
            end
        end
    end
`else
    logic unused_awid;
    assign unused_awid = (AWID > 4);
    assign found_c     = '0;
    assign conflict_c  = '0;

    always_comb begin
        for (int p = 0; p < NPORT; p++) ldo_c[p] = bus.i[p];
    end
`endif

    // Duplicates are acknowledged without consuming a slot; real writes pack densely from tail.
    always_comb begin : enqueue
        int   free_slots;
        int   used;
        logic dup;
        free_slots    = QDEP - int'(cnt) + int'(pop);
        used          = 0;
        dup           = 1'b0;
        accepted      = '0;
        written       = '0;
        next_last_tid = last_tid;
        for (int p = 0; p < NPORT; p++) begin
            wr_idx[p] = tail + PW'(used);
            dup = (bus.i[p].tid == last_tid);
            for (int q = 0; q < p; q++) begin
                if (accepted[q] && bus.i[q].tid == bus.i[p].tid) dup = 1'b1;
            end
            if (bus.wr[p] && !found_c[p] && !conflict_c[p]) begin
                if (dup) begin
                    accepted[p] = 1'b1;
                end else if (used < free_slots) begin
                    accepted[p]   = 1'b1;
                    written[p]    = 1'b1;
                    used          = used + 1;
                    next_last_tid = bus.i[p].tid;
                end
            end
        end
        n_written = CW'(used);
    end

    // Pop clears first so a write landing in the just-freed slot keeps its valid bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            vld      <= '0;
            ack_q    <= '0;
            last_tid <= 8'hFF;
        end else begin
            ack_q <= bus.wr & (found_c | accepted);
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + PW'(1);
            end
            for (int p = 0; p < NPORT; p++) begin
                if (written[p]) vld[wr_idx[p]] <= 1'b1;
            end
            tail     <= tail + PW'(n_written);
            cnt      <= cnt + n_written - CW'(pop);
            last_tid <= next_last_tid;
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (written[p]) begin
                mem[wr_idx[p]] <= bus.i[p];
`ifdef BW_SQ_FWD_EN
                msk[wr_idx[p]] <= byte_mask(bus.i[p]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_bw_store_fwd_queue.sv
// Scoreboard bench for bw_store_fwd_queue: entries expected at o are queued as they are driven
// and compared whenever the DUT pops; forwarding checks follow BW_SQ_FWD_EN.
module tb_bw_store_fwd_queue;
    import bw_sq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    MemoryRequest exp_q [$];
    MemoryRequest nop_req;

    always #5 clk = ~clk;

    bw_store_fwd_queue_if #(.QDEP(8), .NPORT(2)) bus ();

    bw_store_fwd_queue #(.QDEP(8), .NPORT(2), .AWID(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic MemoryRequest mk(input mr_func_t f, input logic [31:0] a, input mr_size_t s,
                                        input logic [63:0] d, input logic [7:0] t);
        MemoryRequest r;
        r.func = f;
        r.adr  = a;
        r.sz   = s;
        r.dat  = d;
        r.tid  = t;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr = 2'b00;
        bus.rd = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] wr_v, input MemoryRequest r0,
                                 input MemoryRequest r1, input logic rd_v);
        bus.i[0] = r0;
        bus.i[1] = r1;
        bus.wr   = wr_v;
        bus.rd   = rd_v;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        checkOutput("rst_count", 128'(bus.count), 128'(0));
        checkOutput("rst_empty", 128'(bus.empty), 128'(1));
        checkOutput("rst_valid", 128'(bus.valid), 128'(0));
        checkOutput("rst_ack", 128'(bus.wr_ack), 128'(0));
    endtask

    task automatic drain(input int n);
        bus.wr = 2'b00;
        bus.rd = 1'b1;
        repeat (n) tick();
        bus.rd = 1'b0;
        checkOutput("drain_empty", 128'(bus.empty), 128'(1));
        checkOutput("drain_sb", 128'(exp_q.size()), 128'(0));
    endtask

    // Head comparison happens mid-cycle, before the edge that actually pops.
    always @(negedge clk) begin
        MemoryRequest e;
        if (rst && bus.rd && bus.valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_spurious_pop", 128'(bus.valid), 128'(0));
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_head", 128'(bus.o), 128'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        MemoryRequest r;
        MemoryRequest r9;
        MemoryRequest ld;
        nop_req = mk(MR_NOP, 32'h0, SZ_BYT, 64'h0, 8'h00);
        bus.i[0] = nop_req;
        bus.i[1] = nop_req;
        idle();

        $display("[TB] fill to full, refuse, then accept with pop");
        do_reset();
        checkOutput("rst_full", 128'(bus.full), 128'(0));
        for (int n = 0; n < 8; n++) begin
            r = mk(MR_STORE, 32'h100 + 32'(n * 16), SZ_OCTA, 64'hA000 + 64'(n), 8'(n + 1));
            applyStimulus(2'b01, r, nop_req, 1'b0);
            exp_q.push_back(r);
            tick();
            checkOutput("fill_ack", 128'(bus.wr_ack), 128'(2'b01));
        end
        idle();
        checkOutput("fill_count", 128'(bus.count), 128'(8));
        checkOutput("fill_full", 128'(bus.full), 128'(1));
        r9 = mk(MR_STORE, 32'h200, SZ_OCTA, 64'hA009, 8'h09);
        applyStimulus(2'b01, r9, nop_req, 1'b0);
        tick();
        checkOutput("full_refuse_ack", 128'(bus.wr_ack), 128'(0));
        checkOutput("full_refuse_count", 128'(bus.count), 128'(8));
        applyStimulus(2'b01, r9, nop_req, 1'b1);
        exp_q.push_back(r9);
        tick();
        checkOutput("full_pop_ack", 128'(bus.wr_ack), 128'(2'b01));
        checkOutput("full_pop_count", 128'(bus.count), 128'(8));
        idle();
        drain(8);

        $display("[TB] store-to-load forwarding");
        do_reset();
        r = mk(MR_STORE, 32'h1000, SZ_OCTA, 64'h8877665544332211, 8'h10);
        applyStimulus(2'b01, r, nop_req, 1'b0);
        exp_q.push_back(r);
        tick();
        idle();
        ld = mk(MR_LOAD, 32'h1003, SZ_BYT, 64'h0, 8'h11);
        applyStimulus(2'b10, nop_req, ld, 1'b0);
`ifdef BW_SQ_FWD_EN
        checkOutput("fwd_found", 128'(bus.found[1]), 128'(1));
        checkOutput("fwd_conflict", 128'(bus.conflict[1]), 128'(0));
        checkOutput("fwd_byte3", 128'(bus.ldo[1].dat), 128'(64'h44));
        tick();
        checkOutput("fwd_ack", 128'(bus.wr_ack), 128'(2'b10));
        ld = mk(MR_LOAD, 32'h1007, SZ_BYT, 64'h0, 8'h12);
        applyStimulus(2'b10, nop_req, ld, 1'b0);
        checkOutput("fwd_sext", 128'(bus.ldo[1].dat), 128'(64'hFFFF_FFFF_FFFF_FF88));
        tick();
        ld = mk(MR_LOADZ, 32'h1007, SZ_BYT, 64'h0, 8'h13);
        applyStimulus(2'b10, nop_req, ld, 1'b0);
        checkOutput("fwd_zext", 128'(bus.ldo[1].dat), 128'(64'h88));
        tick();
        checkOutput("fwd_count", 128'(bus.count), 128'(1));
`else
        checkOutput("nofwd_found", 128'(bus.found[1]), 128'(0));
        checkOutput("nofwd_ldo", 128'(bus.ldo[1]), 128'(ld));
        exp_q.push_back(ld);
        tick();
        checkOutput("nofwd_ack", 128'(bus.wr_ack), 128'(2'b10));
        checkOutput("nofwd_count", 128'(bus.count), 128'(2));
`endif
        idle();
        drain(exp_q.size());

        $display("[TB] partial overlap");
        do_reset();
        r = mk(MR_STORE, 32'h2000, SZ_WYDE, 64'hBEEF, 8'h20);
        applyStimulus(2'b01, r, nop_req, 1'b0);
        exp_q.push_back(r);
        tick();
        idle();
        ld = mk(MR_LOAD, 32'h2000, SZ_TETRA, 64'h0, 8'h21);
        applyStimulus(2'b10, nop_req, ld, 1'b0);
`ifdef BW_SQ_FWD_EN
        checkOutput("cfl_conflict", 128'(bus.conflict[1]), 128'(1));
        checkOutput("cfl_found", 128'(bus.found[1]), 128'(0));
        tick();
        checkOutput("cfl_ack", 128'(bus.wr_ack), 128'(0));
        checkOutput("cfl_count", 128'(bus.count), 128'(1));
`else
        checkOutput("nofwd_conflict", 128'(bus.conflict[1]), 128'(0));
        exp_q.push_back(ld);
        tick();
        checkOutput("nofwd_cfl_ack", 128'(bus.wr_ack), 128'(2'b10));
        checkOutput("nofwd_cfl_count", 128'(bus.count), 128'(2));
`endif
        idle();
        drain(exp_q.size());

        $display("[TB] duplicate tid suppression");
        do_reset();
        r  = mk(MR_STORE, 32'h3000, SZ_OCTA, 64'h5050, 8'h05);
        ld = mk(MR_STORE, 32'h3010, SZ_OCTA, 64'h5151, 8'h05);
        applyStimulus(2'b11, r, ld, 1'b0);
        exp_q.push_back(r);
        tick();
        checkOutput("dup_ack_both", 128'(bus.wr_ack), 128'(2'b11));
        checkOutput("dup_count", 128'(bus.count), 128'(1));
        r = mk(MR_STORE, 32'h3020, SZ_OCTA, 64'h5252, 8'h05);
        applyStimulus(2'b01, r, nop_req, 1'b0);
        tick();
        checkOutput("dup_last_ack", 128'(bus.wr_ack), 128'(2'b01));
        checkOutput("dup_last_count", 128'(bus.count), 128'(1));
        idle();
        drain(1);

        $display("[TB] wraparound streaming");
        do_reset();
        for (int n = 0; n < 3; n++) begin
            r = mk(MR_STORE, 32'h4000 + 32'(n * 16), SZ_OCTA, 64'hC000 + 64'(n), 8'(8'h30 + n));
            applyStimulus(2'b01, r, nop_req, 1'b0);
            exp_q.push_back(r);
            tick();
        end
        for (int n = 0; n < 12; n++) begin
            r = mk(MR_STORE, 32'h5000 + 32'(n * 16), SZ_OCTA, 64'hD000 + 64'(n), 8'(8'h40 + n));
            applyStimulus(2'b01, r, nop_req, 1'b1);
            exp_q.push_back(r);
            tick();
            checkOutput("wrap_count", 128'(bus.count), 128'(3));
        end
        idle();
        drain(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
